// File: rtl/cp0_pkg.sv
// ============================================================
// cp0_pkg : CP0 register numbers, ExcCodes and field positions
// Revision 1.0
// ============================================================
`default_nettype none

package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LSB = 8;
  localparam int STATUS_BEV    = 22;

  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_BD      = 31;

  // Only address-error exceptions carry a meaningful faulting address
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================
// cp0_timer : Count/Compare with clock divider and timer interrupt
// Revision 1.0
// ============================================================
`default_nettype none

module cp0_timer #(
  parameter int TICK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int             DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic [31:0]      r_count;
  logic [31:0]      r_compare;
  logic             r_ti;
  logic             w_tick;
  logic [31:0]      w_count_inc;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (count_we) begin
        r_count <= wdata;
        r_div   <= '0;
      end else if (w_tick) begin
        r_count <= w_count_inc;
        r_div   <= '0;
      end else begin
        r_div <= r_div + DIV_ONE;
      end

      if (compare_we) begin
        r_compare <= wdata;
      end

      // A Compare write acknowledges the interrupt and beats a same-cycle match
      if (compare_we) begin
        r_ti <= 1'b0;
      end else if (!count_we && w_tick && (w_count_inc == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_ctrl.sv
// ============================================================
// cp0_ctrl : CP0 registers, exception/ERET/MTC0 commit, interrupts
// Revision 1.0
// ============================================================
`default_nettype none

module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int NUM_HW_INT = 6,
  parameter int TICK_DIV   = 2,
  parameter int TI_IP_BIT  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic                  mtc0_we,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic                  ex_valid,
  input  logic [4:0]            ex_code,
  input  logic                  ex_bd,
  input  logic [31:0]           ex_pc,
  input  logic [31:0]           ex_badvaddr,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  int_req,
  output logic [31:0]           epc_out,
  output logic                  exl_out
);

  logic [7:0]            r_im;
  logic                  r_exl;
  logic                  r_ie;
  logic                  r_bd;
  logic [4:0]            r_exc_code;
  logic [NUM_HW_INT-1:0] r_hw_ip;
  logic [1:0]            r_sw_ip;
  logic [31:0]           r_epc;
  logic [31:0]           r_badvaddr;
  logic                  r_int_req;

  logic                  w_mtc0;
  logic [31:0]           w_count;
  logic [31:0]           w_compare;
  logic                  w_ti;
  logic [7:0]            w_ip;
  logic [31:0]           w_status;
  logic [31:0]           w_cause;

  // MTC0 only commits when neither an exception nor ERET claims the cycle
  assign w_mtc0 = mtc0_we & ~ex_valid & ~eret;

  cp0_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (w_mtc0 && (mtc0_addr == REG_COUNT)),
    .compare_we (w_mtc0 && (mtc0_addr == REG_COMPARE)),
    .wdata      (mtc0_wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  always_comb begin
    w_ip = '0;
    w_ip[1:0] = r_sw_ip;
    for (int i = 0; i < NUM_HW_INT; i++) begin
      w_ip[2+i] = r_hw_ip[i];
    end
    w_ip[TI_IP_BIT] = w_ip[TI_IP_BIT] | w_ti;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exc_code <= '0;
      r_hw_ip    <= '0;
      r_sw_ip    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_int_req  <= 1'b0;
    end else begin
      r_hw_ip   <= hw_int;
      r_int_req <= r_ie & ~r_exl & (|(w_ip & r_im));

      if (ex_valid) begin
        r_exc_code <= ex_code;
        r_exl      <= 1'b1;
        // Nested exceptions keep the original return point
        if (!r_exl) begin
          r_epc <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
          r_bd  <= ex_bd;
        end
        if (is_addr_exc(ex_code)) begin
          r_badvaddr <= ex_badvaddr;
        end
      end else if (eret) begin
        r_exl <= 1'b0;
      end else if (mtc0_we) begin
        case (mtc0_addr)
          REG_STATUS: begin
            r_im  <= mtc0_wdata[STATUS_IM_LSB +: 8];
            r_exl <= mtc0_wdata[STATUS_EXL];
            r_ie  <= mtc0_wdata[STATUS_IE];
          end
          REG_CAUSE: r_sw_ip <= mtc0_wdata[CAUSE_IP_LSB +: 2];
          REG_EPC:   r_epc   <= mtc0_wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    w_status = '0;
    w_status[STATUS_BEV]         = 1'b1;
    w_status[STATUS_IM_LSB +: 8] = r_im;
    w_status[STATUS_EXL]         = r_exl;
    w_status[STATUS_IE]          = r_ie;

    w_cause = '0;
    w_cause[CAUSE_BD]           = r_bd;
    w_cause[CAUSE_TI]           = w_ti;
    w_cause[CAUSE_IP_LSB +: 8]  = w_ip;
    w_cause[CAUSE_EXC_LSB +: 5] = r_exc_code;

    case (raddr)
      REG_BADVADDR: rdata = r_badvaddr;
      REG_COUNT:    rdata = w_count;
      REG_COMPARE:  rdata = w_compare;
      REG_STATUS:   rdata = w_status;
      REG_CAUSE:    rdata = w_cause;
      REG_EPC:      rdata = r_epc;
      default:      rdata = '0;
    endcase
  end

  assign int_req = r_int_req;
  assign epc_out = r_epc;
  assign exl_out = r_exl;

endmodule

`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
// ============================================================
// tb_cp0_ctrl : directed and randomized checks against a CP0 model
// Revision 1.0
// ============================================================
`default_nettype none

module tb_cp0_ctrl;
  import cp0_pkg::*;

  localparam int NUM_HW_INT = 6;
  localparam int TICK_DIV   = 2;
  localparam int TI_IP_BIT  = 7;

  logic                  clk;
  logic                  reset;
  logic [4:0]            raddr;
  logic [31:0]           rdata;
  logic                  mtc0_we;
  logic [4:0]            mtc0_addr;
  logic [31:0]           mtc0_wdata;
  logic                  ex_valid;
  logic [4:0]            ex_code;
  logic                  ex_bd;
  logic [31:0]           ex_pc;
  logic [31:0]           ex_badvaddr;
  logic                  eret;
  logic [NUM_HW_INT-1:0] hw_int;
  logic                  int_req;
  logic [31:0]           epc_out;
  logic                  exl_out;

  int checks = 0;
  int errors = 0;

  cp0_ctrl #(
    .NUM_HW_INT (NUM_HW_INT),
    .TICK_DIV   (TICK_DIV),
    .TI_IP_BIT  (TI_IP_BIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raddr       (raddr),
    .rdata       (rdata),
    .mtc0_we     (mtc0_we),
    .mtc0_addr   (mtc0_addr),
    .mtc0_wdata  (mtc0_wdata),
    .ex_valid    (ex_valid),
    .ex_code     (ex_code),
    .ex_bd       (ex_bd),
    .ex_pc       (ex_pc),
    .ex_badvaddr (ex_badvaddr),
    .eret        (eret),
    .hw_int      (hw_int),
    .int_req     (int_req),
    .epc_out     (epc_out),
    .exl_out     (exl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model of CP0, advanced once per clock from the spec's rules
  logic [7:0]            m_im;
  logic                  m_exl, m_ie, m_bd, m_ti, m_int_req;
  logic [4:0]            m_exc;
  logic [NUM_HW_INT-1:0] m_ip_hw;
  logic [1:0]            m_ip_sw;
  logic [31:0]           m_epc, m_bad, m_count, m_compare;
  int                    m_div;

  task automatic model_reset();
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_int_req = 0;
    m_exc = 0; m_ip_hw = 0; m_ip_sw = 0;
    m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0; m_div = 0;
  endtask

  function automatic logic [7:0] model_ip();
    logic [7:0] ip;
    ip = 8'(m_ip_hw) << 2;
    ip[1:0] = m_ip_sw;
    if (m_ti) ip[TI_IP_BIT] = 1'b1;
    return ip;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(model_ip()) << 8) | (32'(m_exc) << 2);
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0]  ip_old;
    logic [31:0] inc;
    logic        do_mtc0;
    if (reset) begin
      model_reset();
      return;
    end
    ip_old  = model_ip();
    inc     = m_count + 32'd1;
    do_mtc0 = mtc0_we && !ex_valid && !eret;
    m_int_req = m_ie && !m_exl && ((ip_old & m_im) != 8'h0);
    m_ip_hw   = hw_int;
    if (do_mtc0 && mtc0_addr == 5'd9) begin
      m_count = mtc0_wdata; m_div = 0;
    end else if (m_div == TICK_DIV - 1) begin
      if (inc == m_compare) m_ti = 1'b1;
      m_count = inc; m_div = 0;
    end else begin
      m_div++;
    end
    if (do_mtc0 && mtc0_addr == 5'd11) begin
      m_compare = mtc0_wdata; m_ti = 1'b0;
    end
    if (ex_valid) begin
      m_exc = ex_code;
      if (!m_exl) begin
        m_epc = ex_bd ? ex_pc - 32'd4 : ex_pc;
        m_bd  = ex_bd;
      end
      m_exl = 1'b1;
      if (ex_code == 5'd4 || ex_code == 5'd5) m_bad = ex_badvaddr;
    end else if (eret) begin
      m_exl = 1'b0;
    end else if (mtc0_we) begin
      if (mtc0_addr == 5'd12) begin
        m_im = mtc0_wdata[15:8]; m_exl = mtc0_wdata[1]; m_ie = mtc0_wdata[0];
      end else if (mtc0_addr == 5'd13) begin
        m_ip_sw = mtc0_wdata[9:8];
      end else if (mtc0_addr == 5'd14) begin
        m_epc = mtc0_wdata;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
    cycle();
    mtc0_we = 1'b0;
  endtask

  task automatic exception(input logic [4:0] code, input logic bd,
                           input logic [31:0] pc, input logic [31:0] bad);
    ex_valid = 1'b1; ex_code = code; ex_bd = bd; ex_pc = pc; ex_badvaddr = bad;
    cycle();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [3] = '{5'd12, 5'd13, 5'd9};
    logic [31:0] vals  [3] = '{32'h0040_0000, 32'h0, 32'h0};
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      raddr = addrs[i]; #1;
      checks++;
      if (rdata !== vals[i]) begin
        errors++; $display("FAIL reset_read reg=%0d got=%h exp=%h", addrs[i], rdata, vals[i]);
      end
    end
    checks++;
    if (int_req !== 1'b0 || exl_out !== 1'b0) begin
      errors++; $display("FAIL reset_outputs int_req=%b exl=%b exp=0/0", int_req, exl_out);
    end
  endtask

  task automatic test_timer();
    bit seen = 0;
    mtc0(REG_COMPARE, 32'd3);
    mtc0(REG_STATUS, 32'h0000_8001);
    raddr = REG_CAUSE;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      checks++;
      if (int_req !== m_int_req || rdata !== exp_read(REG_CAUSE)) begin
        errors++; $display("FAIL timer_step int_req=%b exp=%b cause=%h exp=%h",
                           int_req, m_int_req, rdata, exp_read(REG_CAUSE));
      end
      if (int_req === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || rdata[30] !== 1'b1) begin
      errors++; $display("FAIL timer_fire seen=%0d ti=%b exp=1/1", seen, rdata[30]);
    end
    mtc0(REG_COMPARE, 32'd3);
    checks++;
    if (rdata[30] !== 1'b0) begin
      errors++; $display("FAIL timer_clear ti=%b exp=0", rdata[30]);
    end
    cycle();
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL timer_intreq_clear got=%b exp=0", int_req);
    end
  endtask

  task automatic test_exception();
    exception(EXC_ADEL, 1'b1, 32'hBFC0_0104, 32'h0000_0003);
    raddr = REG_CAUSE; #1;
    checks++;
    if (epc_out !== 32'hBFC0_0100 || rdata !== 32'h8000_0010 || exl_out !== 1'b1) begin
      errors++; $display("FAIL exc_first epc=%h cause=%h exl=%b exp=bfc00100/80000010/1",
                         epc_out, rdata, exl_out);
    end
    raddr = REG_BADVADDR; #1;
    checks++;
    if (rdata !== 32'h3) begin
      errors++; $display("FAIL exc_badvaddr got=%h exp=00000003", rdata);
    end
    exception(EXC_SYS, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    raddr = REG_CAUSE; #1;
    checks++;
    if (epc_out !== 32'hBFC0_0100 || rdata[6:2] !== 5'd8) begin
      errors++; $display("FAIL exc_nested epc=%h code=%0d exp=bfc00100/8", epc_out, rdata[6:2]);
    end
    raddr = REG_BADVADDR; #1;
    checks++;
    if (rdata !== 32'h3) begin
      errors++; $display("FAIL exc_badvaddr_kept got=%h exp=00000003", rdata);
    end
  endtask

  task automatic test_priority();
    eret = 1'b1; cycle(); eret = 1'b0;
    checks++;
    if (exl_out !== 1'b0) begin
      errors++; $display("FAIL eret_clear exl=%b exp=0", exl_out);
    end
    mtc0_we = 1'b1; mtc0_addr = REG_STATUS; mtc0_wdata = 32'h0;
    exception(EXC_OV, 1'b0, 32'h0000_0200, 32'h0);
    mtc0_we = 1'b0;
    raddr = REG_STATUS; #1;
    checks++;
    if (exl_out !== 1'b1 || rdata !== 32'h0040_8003) begin
      errors++; $display("FAIL exc_over_mtc0 exl=%b status=%h exp=1/00408003", exl_out, rdata);
    end
    eret = 1'b1;
    exception(EXC_BP, 1'b0, 32'h0000_0300, 32'h0);
    eret = 1'b0;
    checks++;
    if (exl_out !== 1'b1 || epc_out !== 32'h0000_0200) begin
      errors++; $display("FAIL exc_over_eret exl=%b epc=%h exp=1/00000200", exl_out, epc_out);
    end
    eret = 1'b1; cycle(); eret = 1'b0;
  endtask

  task automatic test_hw_int();
    mtc0(REG_STATUS, 32'h0000_0401);
    hw_int = 6'b000001;
    cycle();
    raddr = REG_CAUSE; #1;
    checks++;
    if (rdata[10] !== 1'b1 || int_req !== 1'b0) begin
      errors++; $display("FAIL hw_sample ip2=%b int_req=%b exp=1/0", rdata[10], int_req);
    end
    cycle();
    checks++;
    if (int_req !== 1'b1) begin
      errors++; $display("FAIL hw_intreq got=%b exp=1", int_req);
    end
    exception(EXC_INT, 1'b0, 32'h0000_0400, 32'h0);
    cycle();
    checks++;
    if (int_req !== 1'b0 || exl_out !== 1'b1) begin
      errors++; $display("FAIL hw_masked_by_exl int_req=%b exl=%b exp=0/1", int_req, exl_out);
    end
    hw_int = '0;
    eret = 1'b1; cycle(); eret = 1'b0;
    cycle();
  endtask

  task automatic test_count_wrap();
    mtc0(REG_COUNT, 32'hFFFF_FFFF);
    raddr = REG_COUNT; #1;
    checks++;
    if (rdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL count_load got=%h exp=ffffffff", rdata);
    end
    repeat (TICK_DIV) cycle();
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL count_wrap got=%h exp=00000000", rdata);
    end
    mtc0(REG_CAUSE, 32'h0000_FF00);
    raddr = REG_CAUSE; #1;
    checks++;
    if (rdata[15:8] !== 8'h03) begin
      errors++; $display("FAIL cause_sw_mask ip=%h exp=03", rdata[15:8]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      ex_valid = ($urandom_range(0, 99) < 6);
      eret     = ($urandom_range(0, 99) < 6);
      mtc0_we  = ($urandom_range(0, 99) < 25);
      case ($urandom_range(0, 6))
        0: ex_code = EXC_INT;  1: ex_code = EXC_ADEL; 2: ex_code = EXC_ADES;
        3: ex_code = EXC_SYS;  4: ex_code = EXC_BP;   5: ex_code = EXC_RI;
        default: ex_code = EXC_OV;
      endcase
      ex_bd       = 1'($urandom);
      ex_pc       = $urandom & 32'hFFFF_FFFC;
      ex_badvaddr = $urandom;
      case ($urandom_range(0, 6))
        0: mtc0_addr = REG_STATUS;  1: mtc0_addr = REG_CAUSE;
        2: mtc0_addr = REG_EPC;     3: mtc0_addr = REG_COUNT;
        4: mtc0_addr = REG_COMPARE; 5: mtc0_addr = REG_BADVADDR;
        default: mtc0_addr = 5'($urandom);
      endcase
      mtc0_wdata = (mtc0_addr == REG_COMPARE) ? m_count + $urandom_range(1, 4) : $urandom;
      if ($urandom_range(0, 9) == 0) hw_int = NUM_HW_INT'($urandom);
      cycle();
      reset = 1'b0; ex_valid = 1'b0; eret = 1'b0; mtc0_we = 1'b0;
      checks++;
      if (int_req !== m_int_req || exl_out !== m_exl || epc_out !== m_epc) begin
        errors++; $display("FAIL rand_outputs n=%0d int_req=%b/%b exl=%b/%b epc=%h/%h",
                           n, int_req, m_int_req, exl_out, m_exl, epc_out, m_epc);
      end
      raddr = 5'($urandom_range(0, 15)); #1;
      checks++;
      if (rdata !== exp_read(raddr)) begin
        errors++; $display("FAIL rand_read n=%0d reg=%0d got=%h exp=%h",
                           n, raddr, rdata, exp_read(raddr));
      end
    end
  endtask

  initial begin
    reset = 1'b1; raddr = '0;
    mtc0_we = 1'b0; mtc0_addr = '0; mtc0_wdata = '0;
    ex_valid = 1'b0; ex_code = '0; ex_bd = 1'b0; ex_pc = '0; ex_badvaddr = '0;
    eret = 1'b0; hw_int = '0;
    test_reset();
    test_timer();
    test_exception();
    test_priority();
    test_hw_int();
    test_count_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
